oam_ctrl: RTL and testbench

// - Owns the 160-byte sprite attribute memory (OAM, 0xFE00-0xFEFF window) and arbitrates its

---
 rtl/oam_ctrl.sv | 155 +++++++++++++++
 tb/tb_oam_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_ctrl.sv
// oam_ctrl: owner of the sprite attribute memory (OAM, 0xFE00-0xFEFF window).
// One physical port shared by DMA writes, PPU sprite-scan reads and CPU
// reads/writes. Per-cycle priority: DMA write edge > PPU read > CPU access.
// Optional build macro OAM_LAST_READ_EN: a blocked CPU read returns the last
// byte the port delivered instead of BLOCK_DATA.
module oam_ctrl #(
    parameter int         OAM_BYTES  = 160,
    parameter logic [7:0] BLOCK_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_wr,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_dout,
    input  logic        dma_occupy,
    input  logic        ppu_busy,
    input  logic        ppu_rd,
    input  logic [7:0]  ppu_a,
    output logic [7:0]  ppu_dout,
    output logic        ppu_valid,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout
);

    // Offsets are 8 bits; one extra bit lets OAM_BYTES up to 256 compare cleanly.
    localparam logic [8:0] LIMIT = 9'(OAM_BYTES);

    // Storage is deliberately not reset.
    logic [7:0] mem_q [0:OAM_BYTES-1];

    logic       dma_wr_q;
    logic       ppu_pend_q, ppu_pend_d;
    logic [7:0] ppu_a_q, ppu_a_d;
    logic [7:0] ppu_dout_q, ppu_dout_d;
    logic       ppu_valid_q;
    logic [7:0] cpu_dout_q, cpu_dout_d;

    logic       dma_edge;
    logic       dma_we;
    logic       ppu_svc;
    logic [7:0] ppu_addr;
    logic [7:0] ppu_rdata;
    logic       port_free;
    logic       cpu_lock;
    logic       cpu_we;
    logic       cpu_rd_en;
    logic [7:0] cpu_rdata;
    logic [7:0] blocked_data;

    // Port arbitration, write enables and read-data selection.
    always_comb begin
        // Only the rising edge of dma_wr commits, so a held request writes once.
        dma_edge  = dma_wr & ~dma_wr_q;
        dma_we    = ~rst & dma_edge & (dma_a[15:8] == 8'hFE)
                    & ({1'b0, dma_a[7:0]} < LIMIT);

        // A fresh ppu_rd is serviced in its own cycle unless a DMA edge owns
        // the port; otherwise it waits in ppu_pend_q. The newest address wins.
        ppu_svc   = (ppu_rd | ppu_pend_q) & ~dma_edge;
        ppu_addr  = ppu_rd ? ppu_a : ppu_a_q;
        ppu_rdata = ({1'b0, ppu_addr} < LIMIT) ? mem_q[ppu_addr] : 8'h00;

        ppu_pend_d = ppu_pend_q;
        if (ppu_svc) begin
            ppu_pend_d = 1'b0;
        end else if (ppu_rd) begin
            ppu_pend_d = 1'b1;
        end
        ppu_a_d    = ppu_rd ? ppu_a : ppu_a_q;
        ppu_dout_d = ppu_svc ? ppu_rdata : ppu_dout_q;

        // CPU writes only land on a free port; a same-cycle read is ignored
        // in favour of the write.
        port_free = ~dma_edge & ~ppu_svc;
        cpu_lock  = dma_occupy | ppu_busy;
        cpu_we    = ~rst & cpu_wr & ~cpu_lock & port_free
                    & ({1'b0, cpu_a} < LIMIT);
        cpu_rd_en = cpu_rd & ~cpu_wr;

        if (cpu_lock) begin
            cpu_rdata = blocked_data;
        end else if ({1'b0, cpu_a} < LIMIT) begin
            cpu_rdata = mem_q[cpu_a];
        end else begin
            cpu_rdata = 8'h00;
        end
        cpu_dout_d = cpu_rd_en ? cpu_rdata : cpu_dout_q;
    end

    // Single write port into the attribute memory; DMA and CPU never coincide.
    always_ff @(posedge clk) begin
        if (dma_we) begin
            mem_q[dma_a[7:0]] <= dma_dout;
        end else if (cpu_we) begin
            mem_q[cpu_a] <= cpu_din;
        end
    end

    // Control and output registers; reset also aborts any pending PPU read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_wr_q    <= 1'b0;
            ppu_pend_q  <= 1'b0;
            ppu_a_q     <= 8'h00;
            ppu_dout_q  <= 8'h00;
            ppu_valid_q <= 1'b0;
            cpu_dout_q  <= 8'h00;
        end else begin
            dma_wr_q    <= dma_wr;
            ppu_pend_q  <= ppu_pend_d;
            ppu_a_q     <= ppu_a_d;
            ppu_dout_q  <= ppu_dout_d;
            ppu_valid_q <= ppu_svc;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

`ifdef OAM_LAST_READ_EN
    logic [7:0] last_q, last_d;

    // Bus-latch model: remember the most recent byte handed to PPU or CPU.
    always_comb begin
        last_d = last_q;
        if (ppu_svc) begin
            last_d = ppu_rdata;
        end
        if (cpu_rd_en & ~cpu_lock) begin
            last_d = cpu_rdata;
        end
        blocked_data = last_q;
    end

    // Latch register for the last delivered byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 8'h00;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Blocked CPU reads see a fixed pattern.
    always_comb begin
        blocked_data = BLOCK_DATA;
    end
`endif

    assign ppu_dout  = ppu_dout_q;
    assign ppu_valid = ppu_valid_q;
    assign cpu_dout  = cpu_dout_q;

endmodule

// File: tb/tb_oam_ctrl.sv
// Testbench for oam_ctrl: scoreboard of expected PPU/CPU read bytes, filled
// when a read is driven and drained when the DUT presents the data.
module tb_oam_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_wr;
    logic [15:0] dma_a;
    logic [7:0]  dma_dout;
    logic        dma_occupy;
    logic        ppu_busy;
    logic        ppu_rd;
    logic [7:0]  ppu_a;
    logic [7:0]  ppu_dout;
    logic        ppu_valid;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_a;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl [0:159];
    logic [7:0] last_mdl = 8'h00;
    logic [7:0] last_cpu = 8'h00;
    logic [7:0] ppu_q [$];
    logic [7:0] cpu_q [$];

    oam_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .dma_wr     (dma_wr),
        .dma_a      (dma_a),
        .dma_dout   (dma_dout),
        .dma_occupy (dma_occupy),
        .ppu_busy   (ppu_busy),
        .ppu_rd     (ppu_rd),
        .ppu_a      (ppu_a),
        .ppu_dout   (ppu_dout),
        .ppu_valid  (ppu_valid),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_a      (cpu_a),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] blk_exp();
`ifdef OAM_LAST_READ_EN
        return last_mdl;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic in_oam(input logic [7:0] a);
        return ({1'b0, a} < 9'd160);
    endfunction

    // Every cycle starts at the falling edge with the one-shot strobes low.
    task automatic cyc_start();
        @(negedge clk);
        ppu_rd = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic dma_byte(input logic [15:0] a, input logic [7:0] d);
        cyc_start();
        dma_wr   = 1'b1;
        dma_a    = a;
        dma_dout = d;
        if (a[15:8] == 8'hFE && in_oam(a[7:0])) mdl[a[7:0]] = d;
        cyc_start();
        cyc_start();
        dma_wr = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cyc_start();
        cpu_wr  = 1'b1;
        cpu_a   = a;
        cpu_din = d;
        if (!(dma_occupy | ppu_busy) && in_oam(a)) mdl[a] = d;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        logic [7:0] e;
        cyc_start();
        cpu_rd = 1'b1;
        cpu_a  = a;
        if (dma_occupy | ppu_busy) begin
            e = blk_exp();
        end else begin
            e = in_oam(a) ? mdl[a] : 8'h00;
            last_mdl = e;
        end
        last_cpu = e;
        cpu_q.push_back(e);
    endtask

    task automatic ppu_read(input logic [7:0] a);
        logic [7:0] e;
        cyc_start();
        ppu_rd = 1'b1;
        ppu_a  = a;
        e = in_oam(a) ? mdl[a] : 8'h00;
        last_mdl = e;
        ppu_q.push_back(e);
    endtask

    // Output monitor: drains the scoreboard just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (ppu_valid) begin
                    if (ppu_q.size() == 0) chk("ppu_extra_valid", 16'd1, 16'd0);
                    else chk("ppu_data", {8'h00, ppu_dout}, {8'h00, ppu_q.pop_front()});
                end
                if (cpu_rd && !cpu_wr) begin
                    if (cpu_q.size() == 0) chk("cpu_extra_read", 16'd1, 16'd0);
                    else chk("cpu_data", {8'h00, cpu_dout}, {8'h00, cpu_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dma_wr = 1'b0; dma_a = 16'h0000; dma_dout = 8'h00;
        dma_occupy = 1'b0; ppu_busy = 1'b0; ppu_rd = 1'b0; ppu_a = 8'h00;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 8'h00; cpu_din = 8'h00;

        // Reset values
        #2;
        chk("rst_ppu_dout", {8'h00, ppu_dout}, 16'h0000);
        chk("rst_ppu_valid", {15'h0, ppu_valid}, 16'h0000);
        chk("rst_cpu_dout", {8'h00, cpu_dout}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // DMA sweep with the CPU locked out, then a blocked read and readback
        dma_occupy = 1'b1;
        for (int i = 0; i < 160; i++) begin
            dma_byte({8'hFE, 8'(i)}, ~8'(i));
        end
        cpu_read(8'h00);
        cyc_start();
        dma_occupy = 1'b0;
        for (int i = 0; i < 160; i++) begin
            cpu_read(8'(i));
        end

        // Held dma_wr: only the rising edge writes
        cyc_start();
        dma_wr = 1'b1; dma_a = 16'hFE10; dma_dout = 8'h55;
        mdl[8'h10] = 8'h55;
        repeat (4) cyc_start();
        dma_a = 16'hFE11; dma_dout = 8'h66;
        repeat (2) cyc_start();
        dma_wr = 1'b0;
        cpu_read(8'h10);
        cpu_read(8'h11);

        // Nominal PPU latency of one cycle
        ppu_read(8'h21);
        @(posedge clk); #1;
        chk("ppu_lat1", {15'h0, ppu_valid}, 16'h0001);

        // PPU read colliding with a DMA edge to the same offset
        cyc_start();
        dma_wr = 1'b1; dma_a = 16'hFE20; dma_dout = 8'h3C;
        ppu_rd = 1'b1; ppu_a = 8'h20;
        mdl[8'h20] = 8'h3C;
        last_mdl = 8'h3C;
        ppu_q.push_back(8'h3C);
        @(posedge clk); #1;
        chk("coll_lat1", {15'h0, ppu_valid}, 16'h0000);
        cyc_start();
        dma_wr = 1'b0;
        @(posedge clk); #1;
        chk("coll_lat2", {15'h0, ppu_valid}, 16'h0001);

        // CPU write loses the port to a same-cycle PPU read
        cyc_start();
        ppu_rd = 1'b1; ppu_a = 8'h06;
        cpu_wr = 1'b1; cpu_a = 8'h06; cpu_din = 8'h11;
        last_mdl = mdl[8'h06];
        ppu_q.push_back(mdl[8'h06]);
        cpu_read(8'h06);

        // Read and write together: write commits, cpu_dout holds
        cyc_start();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h07; cpu_din = 8'h42;
        mdl[8'h07] = 8'h42;
        @(posedge clk); #1;
        chk("rdwr_hold", {8'h00, cpu_dout}, {8'h00, last_cpu});
        cpu_read(8'h07);

        // Lockout by ppu_busy
        cpu_read(8'h30);
        cyc_start();
        ppu_busy = 1'b1;
        cpu_write(8'h05, 8'hAA);
        cpu_read(8'h05);
        cyc_start();
        ppu_busy = 1'b0;
        cpu_read(8'h05);

        // Unusable area
        cpu_write(8'hA0, 8'h77);
        cpu_read(8'hA0);
        ppu_read(8'hC0);
        ppu_read(8'hFF);

        // Async reset while a PPU read is pending
        cyc_start();
        dma_wr = 1'b1; dma_a = 16'hFE40; dma_dout = 8'h99;
        ppu_rd = 1'b1; ppu_a = 8'h41;
        mdl[8'h40] = 8'h99;
        @(posedge clk); #1;
        chk("pend_no_valid", {15'h0, ppu_valid}, 16'h0000);
        #1;
        rst = 1'b1;
        last_mdl = 8'h00;
        last_cpu = 8'h00;
        #1;
        chk("arst_ppu_valid", {15'h0, ppu_valid}, 16'h0000);
        chk("arst_ppu_dout", {8'h00, ppu_dout}, 16'h0000);
        chk("arst_cpu_dout", {8'h00, cpu_dout}, 16'h0000);
        cyc_start();
        dma_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", {15'h0, ppu_valid}, 16'h0000);
        end
        cpu_read(8'h40);
        cpu_read(8'h41);
        cpu_read(8'h42);

        repeat (3) cyc_start();
        chk("ppu_q_empty", 16'(ppu_q.size()), 16'd0);
        chk("cpu_q_empty", 16'(cpu_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
